// File: rtl/latch_bank.sv
// NREGS x WIDTH register bank: edge-detected load strobes, loaded flags and two OR-combined read buses.
// Optional per-register increment strobes are built when LATCH_BANK_INC_EN is defined.
module latch_bank #(
   parameter int unsigned      WIDTH     = 12,
   parameter int unsigned      NREGS     = 4,
   parameter logic [WIDTH-1:0] PRESET    = WIDTH'(12'o4000),
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   input  logic             setvalue,
   input  logic [NREGS-1:0] latch,
   input  logic [NREGS-1:0] clr_loaded,
   input  logic [NREGS-1:0] oe_a,
   input  logic [NREGS-1:0] oe_b,
`ifdef LATCH_BANK_INC_EN
   input  logic [NREGS-1:0] inc,
`endif
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [NREGS-1:0] load_pulse,
   output logic [NREGS-1:0] loaded
);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [NREGS-1:0] latch_prev_q;
   logic [NREGS-1:0] latch_edge;
   logic [NREGS-1:0] pulse_q;
   logic [NREGS-1:0] pulse_d;
   logic [NREGS-1:0] loaded_q;
   logic [NREGS-1:0] loaded_d;
   logic [WIDTH-1:0] src;

   assign latch_edge = latch & ~latch_prev_q;
   assign src        = setvalue ? PRESET : in;

`ifdef LATCH_BANK_INC_EN
   logic [NREGS-1:0] inc_prev_q;
   logic [NREGS-1:0] inc_edge;

   assign inc_edge = inc & ~inc_prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inc_prev_q <= '0;
      end else begin
         inc_prev_q <= inc;
      end
   end
`endif

   // A load edge always beats an increment edge and a same-cycle clear of the loaded flag.
   always_comb begin
      pulse_d  = '0;
      loaded_d = (loaded_q & ~clr_loaded) | latch_edge;
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (latch_edge[i]) begin
            regs_d[i]  = src;
            pulse_d[i] = 1'b1;
         end
`ifdef LATCH_BANK_INC_EN
         else if (inc_edge[i]) begin
            regs_d[i]  = regs_q[i] + WIDTH'(1);
            pulse_d[i] = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
         latch_prev_q <= '0;
         pulse_q      <= '0;
         loaded_q     <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         latch_prev_q <= latch;
         pulse_q      <= pulse_d;
         loaded_q     <= loaded_d;
      end
   end

   always_comb begin
      out_a = '0;
      out_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (oe_a[i]) begin
            out_a = out_a | regs_q[i];
         end
         if (oe_b[i]) begin
            out_b = out_b | regs_q[i];
         end
      end
   end

   assign load_pulse = pulse_q;
   assign loaded     = loaded_q;

endmodule

// File: tb/tb_latch_bank.sv
// Self-checking bench for latch_bank: spec-level model compared every cycle plus literal spot checks.
// Exercises the increment strobes too when LATCH_BANK_INC_EN is defined.
module tb_latch_bank;

   localparam int WIDTH = 12;
   localparam int NREGS = 4;
   localparam logic [WIDTH-1:0] PRESET = 12'o4000;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] in;
   logic             setvalue;
   logic [NREGS-1:0] latch;
   logic [NREGS-1:0] clrLoaded;
   logic [NREGS-1:0] oeA;
   logic [NREGS-1:0] oeB;
   logic [WIDTH-1:0] outA;
   logic [WIDTH-1:0] outB;
   logic [NREGS-1:0] loadPulse;
   logic [NREGS-1:0] loaded;
`ifdef LATCH_BANK_INC_EN
   logic [NREGS-1:0] inc;
`endif

   int total = 0;
   int bad   = 0;
   bit checkEn = 1'b0;

   latch_bank #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in         (in),
      .setvalue   (setvalue),
      .latch      (latch),
      .clr_loaded (clrLoaded),
      .oe_a       (oeA),
      .oe_b       (oeB),
`ifdef LATCH_BANK_INC_EN
      .inc        (inc),
`endif
      .out_a      (outA),
      .out_b      (outB),
      .load_pulse (loadPulse),
      .loaded     (loaded)
   );

   always #5 clk = ~clk;

   // Reference model: register values, last seen strobe levels, pulse and sticky flags.
   logic [WIDTH-1:0] mReg [NREGS];
   logic [NREGS-1:0] mPrevLatch;
   logic [NREGS-1:0] mPrevInc;
   logic [NREGS-1:0] mPulse;
   logic [NREGS-1:0] mLoaded;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) mReg[i] = '0;
         mPrevLatch = '0;
         mPrevInc   = '0;
         mPulse     = '0;
         mLoaded    = '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            bit latchRose;
            bit incRose;
            int bumped;
            latchRose = latch[i] && !mPrevLatch[i];
            incRose   = 1'b0;
`ifdef LATCH_BANK_INC_EN
            incRose   = inc[i] && !mPrevInc[i];
            mPrevInc[i] = inc[i];
`endif
            mPulse[i] = 1'b0;
            if (latchRose) begin
               mReg[i]    = setvalue ? PRESET : in;
               mPulse[i]  = 1'b1;
               mLoaded[i] = 1'b1;
            end else begin
               if (clrLoaded[i]) mLoaded[i] = 1'b0;
               if (incRose) begin
                  bumped    = (int'(mReg[i]) + 1) % 4096;
                  mReg[i]   = WIDTH'(bumped);
                  mPulse[i] = 1'b1;
               end
            end
            mPrevLatch[i] = latch[i];
         end
      end
   end

   function automatic logic [WIDTH-1:0] expBus(input logic [NREGS-1:0] oe);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < NREGS; i++) if (oe[i]) v = v | mReg[i];
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %o expected %o (octal) at %0t", name, act, exp, $time);
      end
   endtask

   // Every negedge the DUT must agree with the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("cyc outA", 32'(outA), 32'(expBus(oeA)));
         checkOutput("cyc outB", 32'(outB), 32'(expBus(oeB)));
         checkOutput("cyc pulse", 32'(loadPulse), 32'(mPulse));
         checkOutput("cyc loaded", 32'(loaded), 32'(mLoaded));
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic applyStimulus(input logic [NREGS-1:0] l, input logic [WIDTH-1:0] d,
                                input logic sv, input logic [NREGS-1:0] clr);
      latch     = l;
      in        = d;
      setvalue  = sv;
      clrLoaded = clr;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset_n = 1'b0;
      applyStimulus('0, '0, 1'b0, '0);
      oeA = '1;
      oeB = '1;
`ifdef LATCH_BANK_INC_EN
      inc = '0;
`endif
      waitCycles(2);
      checkOutput("reset outA", 32'(outA), 32'd0);
      checkOutput("reset outB", 32'(outB), 32'd0);
      checkOutput("reset loaded", 32'(loaded), 32'd0);
      checkOutput("reset pulse", 32'(loadPulse), 32'd0);
      reset_n = 1'b1;
      checkEn = 1'b1;

      // Load reg0 then reset mid-cycle with no clock edge.
      applyStimulus(4'b0001, 12'o0123, 1'b0, '0);
      waitCycles(1);
      checkOutput("pre-reset outA", 32'(outA), 32'(12'o0123));
      applyStimulus('0, 12'o0123, 1'b0, '0);
      waitCycles(1);
      reset_n = 1'b0;
      #1;
      checkOutput("async reset outA", 32'(outA), 32'd0);
      checkOutput("async reset loaded", 32'(loaded), 32'd0);
      waitCycles(1);
      reset_n = 1'b1;

      // Held strobe on reg2 loads once; later input changes are ignored.
      oeA = 4'b0100;
      oeB = 4'b0000;
      applyStimulus(4'b0100, 12'o1234, 1'b0, '0);
      waitCycles(1);
      checkOutput("held first outA", 32'(outA), 32'(12'o1234));
      checkOutput("held first pulse", 32'(loadPulse), 32'b0100);
      applyStimulus(4'b0100, 12'o7777, 1'b0, '0);
      waitCycles(4);
      checkOutput("held later outA", 32'(outA), 32'(12'o1234));
      checkOutput("held later pulse", 32'(loadPulse), 32'd0);
      checkOutput("held loaded", 32'(loaded), 32'b0100);
      applyStimulus('0, 12'o7777, 1'b0, '0);
      waitCycles(1);

      // Preset into reg0, 0017 into reg1, then overlapping bus enables.
      applyStimulus(4'b0001, 12'o0000, 1'b1, '0);
      waitCycles(1);
      applyStimulus(4'b0000, 12'o0017, 1'b0, '0);
      waitCycles(1);
      applyStimulus(4'b0010, 12'o0017, 1'b0, '0);
      waitCycles(1);
      applyStimulus(4'b0000, 12'o0017, 1'b0, '0);
      oeA = 4'b0011;
      oeB = 4'b0001;
      #1;
      checkOutput("preset outA", 32'(outA), 32'(12'o4017));
      checkOutput("preset outB", 32'(outB), 32'(12'o4000));
      waitCycles(1);

      // Load and clear on the same edge: set wins; then clear alone.
      applyStimulus(4'b0010, 12'o0017, 1'b0, 4'b0010);
      waitCycles(1);
      checkOutput("set wins loaded1", 32'(loaded[1]), 32'd1);
      applyStimulus(4'b0000, 12'o0017, 1'b0, 4'b0010);
      waitCycles(1);
      checkOutput("clear loaded1", 32'(loaded[1]), 32'd0);
      applyStimulus(4'b0000, 12'o0017, 1'b0, '0);

      // Two channels loading on one edge share the source value.
      oeA = 4'b0101;
      oeB = 4'b0100;
      applyStimulus(4'b0101, 12'o3210, 1'b0, '0);
      waitCycles(1);
      checkOutput("multi pulse", 32'(loadPulse), 32'b0101);
      checkOutput("multi outB", 32'(outB), 32'(12'o3210));
      applyStimulus('0, 12'o3210, 1'b0, '0);
      waitCycles(1);

      // Strobe held across reset release loads exactly once.
      reset_n = 1'b0;
      applyStimulus(4'b1000, 12'o0555, 1'b0, '0);
      oeA = 4'b1000;
      waitCycles(2);
      reset_n = 1'b1;
      waitCycles(1);
      checkOutput("rst-held pulse", 32'(loadPulse), 32'b1000);
      checkOutput("rst-held outA", 32'(outA), 32'(12'o0555));
      applyStimulus(4'b1000, 12'o0666, 1'b0, '0);
      waitCycles(3);
      checkOutput("rst-held later pulse", 32'(loadPulse), 32'd0);
      checkOutput("rst-held later outA", 32'(outA), 32'(12'o0555));
      applyStimulus('0, 12'o0666, 1'b0, '0);
      waitCycles(1);

`ifdef LATCH_BANK_INC_EN
      // Increment wraps, does not set loaded, and loses to a same-edge load.
      oeA = 4'b0001;
      applyStimulus(4'b0001, 12'o7777, 1'b0, '0);
      waitCycles(1);
      applyStimulus('0, 12'o7777, 1'b0, 4'b0001);
      inc = 4'b0001;
      waitCycles(1);
      checkOutput("inc wrap outA", 32'(outA), 32'd0);
      checkOutput("inc pulse", 32'(loadPulse), 32'b0001);
      checkOutput("inc loaded0", 32'(loaded[0]), 32'd0);
      inc = '0;
      applyStimulus('0, 12'o0005, 1'b0, '0);
      waitCycles(1);
      applyStimulus(4'b0001, 12'o0005, 1'b0, '0);
      inc = 4'b0001;
      waitCycles(1);
      checkOutput("latch beats inc", 32'(outA), 32'(12'o0005));
      inc = '0;
      applyStimulus('0, 12'o0005, 1'b0, '0);
      waitCycles(1);
`endif

      waitCycles(2);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/latch_bank.md
Name: latch_bank

Overview:
- Parametrised bank of NREGS edge-triggered data registers, each WIDTH bits wide, loaded from a shared input bus or a preset constant.
- Successor to the fixed two-register latch used around the PDP-8 datapath: arbitrary register count and width, per-register load pulses and loaded flags.
- Two independent OR-combined read buses (A and B), each with per-register output enables.
- Sits between the processor's shared data bus and the register-file consumers.

Parameters:
- WIDTH, 12, data width of every register and both buses
- NREGS, 4, number of registers / strobe channels (1..16)
- PRESET, 12'o4000, constant loaded instead of in when setvalue=1
- RESET_VAL, 0, value of every register after reset

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- in  input  WIDTH  shared load data
- setvalue  input  1  1 = load PRESET instead of in
- latch  input  NREGS  per-register load strobes, rising-edge detected
- clr_loaded  input  NREGS  per-register clear of loaded flag, level, synchronous
- oe_a  input  NREGS  per-register enable onto out_a
- oe_b  input  NREGS  per-register enable onto out_b
- out_a  output  WIDTH  bitwise OR of all registers with oe_a set, else 0
- out_b  output  WIDTH  bitwise OR of all registers with oe_b set, else 0
- load_pulse  output  NREGS  one-cycle registered pulse, register i loaded this cycle
- loaded  output  NREGS  sticky: register i loaded since reset or last clear

Behaviour:
- Reset: reset_n low asynchronously sets all registers=RESET_VAL, edge-history regs=0, load_pulse=0, loaded=0. out_a/out_b therefore equal RESET_VAL-OR per enables (0 with defaults).
- Edge detect per channel i: prev[i]<=latch[i] every clk. Load when latch[i]&~prev[i].
- Source: src = setvalue ? PRESET[WIDTH-1:0] : in, sampled on the same clk as the detected edge.
- Latency: strobe rises before edge k; register updated at edge k; visible on buses after edge k.
- Held strobe: exactly one load per rising edge. Strobe held high across reset release loads once at the first clk edge (prev resets to 0).
- Multiple channels may load on the same edge, all with the same src.
- load_pulse[i]: high for exactly the cycle after edge k, low otherwise.
- loaded[i]: set on load, cleared by clr_loaded[i]. Load and clear on the same edge: set wins.
- Read buses are purely combinational from registers and enables. No enables gives 0. Same register on both buses is allowed.
- Reset mid-operation: pending edges are discarded; no load on the edge coinciding with reset_n low.

Optional Feature:
- Macro LATCH_BANK_INC_EN.
- Defined: extra port inc (input, NREGS), rising-edge detected the same way as latch. On an inc edge, register i <= register i + 1 mod 2^WIDTH (4095 wraps to 0 at WIDTH=12). Pulses load_pulse[i] but does not set loaded[i]. A latch edge and an inc edge on the same clk: latch wins, no increment.
- Undefined: no inc port, no increment logic.

Test Plan:
- Reset with defaults, all oe high -> out_a=out_b=0, loaded=0, load_pulse=0. Assert reset_n mid-cycle -> outputs clear with no clk edge.
- in=12'o1234, latch[2] high 5 cycles, oe_a[2]=1 -> reg2=1234 after first edge only. Change in to 7777 while held -> reg2 stays 1234. load_pulse[2] high 1 cycle, loaded[2]=1.
- setvalue=1, in=0, latch[0] rising -> reg0=4000. oe_a={0,1}, oe_b={1}, reg1=0017 -> out_a=4017, out_b=4000 (octal, oe bit0=reg0).
- latch[1] rising with clr_loaded[1]=1 -> loaded[1]=1. Next cycle clr_loaded[1]=1, no strobe -> loaded[1]=0.
- latch[3] held high while reset_n released -> single load at first edge, then no further loads.
- LATCH_BANK_INC_EN: reg0=7777, inc[0] rising -> reg0=0000. Simultaneous latch[0] edge with in=0005 and inc[0] edge -> reg0=0005.
